mem_arbiter: RTL and testbench

- Shares the single physical memory port between instruction fetch (I side, read-only) and the data-side memory path (D side, read/write with byte mask) of the LC-3b pipeline.
- The D side here is the output of the indirect-access stage.
- Serialises requests with D-priority and bounded I starvation; one transaction in flight at a time.
- Sits between the pipeline's two memory interfaces and physical memory.

---
 rtl/mem_arbiter_pkg.sv | 19 +
 rtl/arb_starve_counter.sv | 36 +++
 rtl/mem_arbiter.sv | 129 ++++++++++++
 tb/tb_mem_arbiter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the LC-3b memory arbiter.
//   lc3b_word      : 16-bit machine word / address
//   lc3b_mem_wmask : 2-bit byte write mask
//   lc3b_arb_state : arbiter FSM states
package mem_arbiter_pkg;

  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  lc3b_mem_wmask;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } lc3b_arb_state;

  // Width of the starvation counter; limits above 15 are not representable.
  localparam int unsigned STARVE_CNT_W = 4;

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating starvation counter for the memory arbiter.
//   clk, rst_n  : clock, async active-low reset
//   i_inc       : count one more D grant taken while I was waiting
//   i_clr       : clear (takes priority over i_inc)
//   o_at_limit  : count has reached STARVE_LIMIT
module arb_starve_counter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_at_limit
);

  localparam int unsigned CNT_W = STARVE_CNT_W;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] r_count;

  // Saturate at the limit so the I side keeps priority until it is served.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != LIMIT)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_at_limit = (r_count == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one physical memory port between LC-3b fetch (I, read-only)
// and the data path (D, read/write with byte mask). D has priority; I is
// granted after STARVE_LIMIT consecutive D grants taken while I was waiting.
// One transaction in flight; at least one IDLE cycle between transactions.
//   clk, rst_n        : clock, async active-low reset
//   i_mem_*           : fetch request / response
//   d_mem_*           : data-side request / response
//   pmem_*            : physical memory port
//   grant_d           : current or most recent grant went to D
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_mem_read,
  input  logic [15:0] i_mem_address,
  output logic        i_mem_resp,
  output logic [15:0] i_mem_rdata,
  input  logic        d_mem_read,
  input  logic        d_mem_write,
  input  logic [15:0] d_mem_address,
  input  logic [15:0] d_mem_wdata,
  input  logic [1:0]  d_mem_byte_enable,
  output logic        d_mem_resp,
  output logic [15:0] d_mem_rdata,
  output logic        pmem_read,
  output logic        pmem_write,
  output logic [15:0] pmem_address,
  output logic [15:0] pmem_wdata,
  output logic [1:0]  pmem_byte_enable,
  input  logic        pmem_resp,
  input  logic [15:0] pmem_rdata,
  output logic        grant_d
);

  lc3b_arb_state r_state;
  logic          r_grant_d;

  logic w_d_req;
  logic w_i_req;
  logic w_at_limit;
  logic w_go_d;
  logic w_go_i;
  logic w_inc;
  logic w_clr;

  assign w_d_req = d_mem_read | d_mem_write;
  assign w_i_req = i_mem_read;

  // Arbitration decision, only meaningful while IDLE.
  assign w_go_d = w_d_req && (!w_i_req || !w_at_limit);
  assign w_go_i = w_i_req && !w_go_d;

  // Count D grants that made a waiting I wait longer; any idle moment
  // without an I request, or an I grant, resets the tally.
  assign w_inc = (r_state == IDLE) && w_go_d && w_i_req;
  assign w_clr = (r_state == IDLE) && (w_go_i || !w_i_req);

  arb_starve_counter #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_inc     (w_inc),
    .i_clr     (w_clr),
    .o_at_limit(w_at_limit)
  );

  // State and grant register; a dropped request does not end service early.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_grant_d <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_go_d) begin
            r_state   <= SERVE_D;
            r_grant_d <= 1'b1;
          end else if (w_go_i) begin
            r_state   <= SERVE_I;
            r_grant_d <= 1'b0;
          end
        end
        SERVE_I, SERVE_D: begin
          if (pmem_resp) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Port steering: the granted side drives pmem and alone sees resp.
  always_comb begin
    pmem_read        = 1'b0;
    pmem_write       = 1'b0;
    pmem_address     = 16'h0000;
    pmem_wdata       = 16'h0000;
    pmem_byte_enable = 2'b00;
    i_mem_resp       = 1'b0;
    d_mem_resp       = 1'b0;
    case (r_state)
      SERVE_D: begin
        pmem_address     = d_mem_address;
        pmem_wdata       = d_mem_wdata;
        pmem_byte_enable = d_mem_byte_enable;
        pmem_write       = d_mem_write;
        pmem_read        = d_mem_read & ~d_mem_write;
        d_mem_resp       = pmem_resp;
      end
      SERVE_I: begin
        pmem_address = i_mem_address;
        pmem_read    = 1'b1;
        i_mem_resp   = pmem_resp;
      end
      default: ;
    endcase
  end

  // Read data is broadcast; consumers qualify it with their resp.
  assign i_mem_rdata = pmem_rdata;
  assign d_mem_rdata = pmem_rdata;
  assign grant_d     = r_grant_d;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized bench for mem_arbiter with a transaction-level
// arbitration model.
module tb_mem_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_mem_read;
  logic [15:0] i_mem_address;
  logic        i_mem_resp;
  logic [15:0] i_mem_rdata;
  logic        d_mem_read;
  logic        d_mem_write;
  logic [15:0] d_mem_address;
  logic [15:0] d_mem_wdata;
  logic [1:0]  d_mem_byte_enable;
  logic        d_mem_resp;
  logic [15:0] d_mem_rdata;
  logic        pmem_read;
  logic        pmem_write;
  logic [15:0] pmem_address;
  logic [15:0] pmem_wdata;
  logic [1:0]  pmem_byte_enable;
  logic        pmem_resp;
  logic [15:0] pmem_rdata;
  logic        grant_d;

  mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_mem_read       (i_mem_read),
    .i_mem_address    (i_mem_address),
    .i_mem_resp       (i_mem_resp),
    .i_mem_rdata      (i_mem_rdata),
    .d_mem_read       (d_mem_read),
    .d_mem_write      (d_mem_write),
    .d_mem_address    (d_mem_address),
    .d_mem_wdata      (d_mem_wdata),
    .d_mem_byte_enable(d_mem_byte_enable),
    .d_mem_resp       (d_mem_resp),
    .d_mem_rdata      (d_mem_rdata),
    .pmem_read        (pmem_read),
    .pmem_write       (pmem_write),
    .pmem_address     (pmem_address),
    .pmem_wdata       (pmem_wdata),
    .pmem_byte_enable (pmem_byte_enable),
    .pmem_resp        (pmem_resp),
    .pmem_rdata       (pmem_rdata),
    .grant_d          (grant_d)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int starve_m = 0;
  bit grant_d_m = 1'b0;
  bit i_pend = 1'b0;
  bit d_pend = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_port_idle(input string tag);
    chk({tag, "_pread"},  32'(pmem_read), 32'd0);
    chk({tag, "_pwrite"}, 32'(pmem_write), 32'd0);
    chk({tag, "_iresp"},  32'(i_mem_resp), 32'd0);
    chk({tag, "_dresp"},  32'(d_mem_resp), 32'd0);
  endtask

  // Runs one transaction from an IDLE cycle whose requests are already driven.
  // Memory answers in the lat-th cycle of service with data rd.
  task automatic do_txn(input int lat, input logic [15:0] rd, input string tag,
                        output bit gd);
    if (d_pend && i_pend) gd = (starve_m != LIMIT);
    else                  gd = d_pend;
    if (gd) starve_m = i_pend ? ((starve_m < LIMIT) ? starve_m + 1 : LIMIT) : 0;
    else    starve_m = 0;
    grant_d_m = gd;

    step();
    @(negedge clk);
    if (gd) begin
      chk({tag, "_pwrite"}, 32'(pmem_write), 32'(d_mem_write));
      chk({tag, "_pread"},  32'(pmem_read), 32'(d_mem_read && !d_mem_write));
      chk({tag, "_paddr"},  32'(pmem_address), 32'(d_mem_address));
      chk({tag, "_pwdata"}, 32'(pmem_wdata), 32'(d_mem_wdata));
      chk({tag, "_pbe"},    32'(pmem_byte_enable), 32'(d_mem_byte_enable));
    end else begin
      chk({tag, "_pwrite"}, 32'(pmem_write), 32'd0);
      chk({tag, "_pread"},  32'(pmem_read), 32'd1);
      chk({tag, "_paddr"},  32'(pmem_address), 32'(i_mem_address));
      chk({tag, "_pbe"},    32'(pmem_byte_enable), 32'd0);
    end
    chk({tag, "_grant"}, 32'(grant_d), 32'(grant_d_m));
    chk({tag, "_count"}, 32'(dut.u_starve.r_count), 32'(starve_m));
    chk({tag, "_noresp"}, 32'({i_mem_resp, d_mem_resp}), 32'd0);
    repeat (lat - 1) @(negedge clk);

    pmem_resp  = 1'b1;
    pmem_rdata = rd;
    #1;
    chk({tag, "_iresp"}, 32'(i_mem_resp), 32'(!gd));
    chk({tag, "_dresp"}, 32'(d_mem_resp), 32'(gd));
    chk({tag, "_irdata"}, 32'(i_mem_rdata), 32'(rd));
    chk({tag, "_drdata"}, 32'(d_mem_rdata), 32'(rd));

    step();
    pmem_resp = 1'b0;
    if (gd) begin
      d_mem_read  = 1'b0;
      d_mem_write = 1'b0;
      d_pend      = 1'b0;
    end else begin
      i_mem_read = 1'b0;
      i_pend     = 1'b0;
    end
    #1;
    chk_port_idle({tag, "_after"});
    chk({tag, "_grant_hold"}, 32'(grant_d), 32'(grant_d_m));
  endtask

  initial begin
    bit gd;
    bit order [6];
    bit exp_order [6];
    exp_order = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

    rst_n = 1'b0;
    i_mem_read = 1'b0; i_mem_address = '0;
    d_mem_read = 1'b0; d_mem_write = 1'b0; d_mem_address = '0;
    d_mem_wdata = '0; d_mem_byte_enable = '0;
    pmem_resp = 1'b0; pmem_rdata = '0;

    // Reset state
    #2;
    chk_port_idle("reset");
    chk("reset_paddr", 32'(pmem_address), 32'd0);
    chk("reset_pwdata", 32'(pmem_wdata), 32'd0);
    chk("reset_pbe", 32'(pmem_byte_enable), 32'd0);
    chk("reset_grant", 32'(grant_d), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step();

    // Lone I read
    i_mem_read = 1'b1; i_mem_address = 16'h3000; i_pend = 1'b1;
    do_txn(2, 16'hBEEF, "lone_i", gd);
    chk("lone_i_grant", 32'(gd), 32'd0);

    // Lone D write
    d_mem_write = 1'b1; d_mem_address = 16'h4002; d_mem_wdata = 16'h1234;
    d_mem_byte_enable = 2'b01; d_pend = 1'b1;
    do_txn(1, 16'h5555, "lone_d", gd);
    chk("lone_d_grant", 32'(gd), 32'd1);

    // Starvation: D re-requests continuously while I waits
    i_mem_read = 1'b1; i_mem_address = 16'h3002; i_pend = 1'b1;
    for (int k = 0; k < 6; k++) begin
      d_mem_read = 1'b1; d_mem_address = 16'h5000 + 16'(2 * k); d_pend = 1'b1;
      if (k == 4) chk("starve_cnt_before_i", 32'(dut.u_starve.r_count), 32'd4);
      do_txn(1 + (k % 3), 16'(16'h0A00 + k), "starve", gd);
      order[k] = gd;
      chk("starve_order", 32'(order[k]), 32'(exp_order[k]));
      if (k == 4) chk("starve_cnt_after_i", 32'(dut.u_starve.r_count), 32'd0);
    end
    d_mem_read = 1'b0; d_pend = 1'b0;
    step();

    // Read and write both asserted on D: write wins
    d_mem_read = 1'b1; d_mem_write = 1'b1; d_mem_address = 16'h6000;
    d_mem_wdata = 16'hCAFE; d_mem_byte_enable = 2'b11; d_pend = 1'b1;
    do_txn(2, 16'h0000, "rw_both", gd);

    // Reset in the middle of a D write
    d_mem_write = 1'b1; d_mem_address = 16'h7000; d_mem_wdata = 16'h00FF;
    d_mem_byte_enable = 2'b10;
    step();
    @(negedge clk);
    chk("rst_mid_pwrite_pre", 32'(pmem_write), 32'd1);
    #2;
    rst_n = 1'b0;
    pmem_resp = 1'b1;
    #1;
    chk_port_idle("rst_mid");
    chk("rst_mid_paddr", 32'(pmem_address), 32'd0);
    chk("rst_mid_pwdata", 32'(pmem_wdata), 32'd0);
    chk("rst_mid_pbe", 32'(pmem_byte_enable), 32'd0);
    chk("rst_mid_grant", 32'(grant_d), 32'd0);
    pmem_resp = 1'b0;
    d_mem_write = 1'b0;
    step();
    rst_n = 1'b1;
    starve_m = 0; grant_d_m = 1'b0; d_pend = 1'b0; i_pend = 1'b0;
    step();
    chk_port_idle("rst_release");

    // Stray pmem_resp in IDLE with nothing pending
    pmem_resp = 1'b1;
    #1;
    chk_port_idle("stray");
    step();
    pmem_resp = 1'b0;
    #1;
    chk_port_idle("stray_after");
    chk("stray_grant", 32'(grant_d), 32'd0);

    // Randomized traffic against the model
    for (int n = 0; n < 60; n++) begin
      if (!i_pend && ($urandom_range(0, 1) == 1)) begin
        i_pend = 1'b1; i_mem_read = 1'b1;
        i_mem_address = 16'($urandom);
      end
      if (!d_pend && (($urandom_range(0, 1) == 1) || !i_pend)) begin
        d_pend = 1'b1;
        case ($urandom_range(0, 2))
          0: begin d_mem_read = 1'b1; d_mem_write = 1'b0; end
          1: begin d_mem_read = 1'b0; d_mem_write = 1'b1; end
          default: begin d_mem_read = 1'b1; d_mem_write = 1'b1; end
        endcase
        d_mem_address = 16'($urandom);
        d_mem_wdata = 16'($urandom);
        d_mem_byte_enable = 2'($urandom);
      end
      do_txn(int'($urandom_range(1, 3)), 16'($urandom), "rand", gd);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
